niosbase_pio_out: RTL

- Avalon-MM slave output PIO for the NiosBase system; the output-direction counterpart of the input PIO.
- The Nios II CPU writes a data register that drives out_port directly.
- Also provides per-bit set/clear writes and a hardware-timed pulse generator, so software can emit fixed-width strobes without busy-wait loops.
- Sits on the system interconnect beside the input PIO; out_port goes to board-level logic.

---
 rtl/niosbase_pio_out_pkg.sv | 31 +++
 rtl/niosbase_pio_out_if.sv | 32 +++
 rtl/niosbase_pio_out_pulse_timer.sv | 70 +++++++
 rtl/niosbase_pio_out.sv | 113 +++++++++++
 4 files changed

// File: rtl/niosbase_pio_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : niosbase_pio_pkg
//  Description : Shared constants and types for the NiosBase output PIO:
//                Avalon word addresses, STATUS bit positions and the pulse
//                timer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package niosbase_pio_pkg;

  localparam int BUS_DW = 32;  // Avalon data bus width
  localparam int ADDR_W = 3;   // Avalon word address width

  localparam logic [ADDR_W-1:0] ADDR_DATA       = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_PULSE_MASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET     = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR     = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_STATUS     = 3'd6;

  // STATUS layout: bit0 = busy, remaining count starts at bit1
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_CNT_LSB  = 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_e;

endpackage : niosbase_pio_pkg
`default_nettype wire

// File: rtl/niosbase_pio_out_if.sv
`default_nettype none
// ============================================================================
//  Module      : niosbase_pio_out_if
//  Description : Avalon-MM slave bus bundle for the output PIO.
//  Signals     : address    [2:0]  word address        (master -> slave)
//                chipselect        slave select        (master -> slave)
//                write_n           active-low write    (master -> slave)
//                writedata  [31:0] write data          (master -> slave)
//                readdata   [31:0] registered readback (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface niosbase_pio_out_if;
  import niosbase_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_DW-1:0] writedata;
  logic [BUS_DW-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface : niosbase_pio_out_if
`default_nettype wire

// File: rtl/niosbase_pio_out_pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module      : niosbase_pio_pulse_timer
//  Description : Hardware-timed pulse generator. A trigger with a nonzero
//                length loads the mask and counter; the mask stays visible
//                for exactly len_i cycles, then clears. Retrigger reloads,
//                abort clears immediately.
//  Ports       : clk, reset_n        clock, async active-low reset
//                trigger_i           start/reload request (mask nonzero)
//                abort_i             stop request (mask write of zero)
//                mask_i, len_i       values captured on trigger
//                active_mask_o       running mask (zero while idle)
//                busy_o              pulse in progress
//                remaining_o         cycles left in the pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module niosbase_pio_pulse_timer
  import niosbase_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PULSE_CNT_W = 16
) (
  input  wire logic                   clk,
  input  wire logic                   reset_n,
  input  wire logic                   trigger_i,
  input  wire logic                   abort_i,
  input  wire logic [DATA_WIDTH-1:0]  mask_i,
  input  wire logic [PULSE_CNT_W-1:0] len_i,
  output logic      [DATA_WIDTH-1:0]  active_mask_o,
  output logic                        busy_o,
  output logic      [PULSE_CNT_W-1:0] remaining_o
);

  pulse_state_e           state_q;
  logic [DATA_WIDTH-1:0]  mask_q;
  logic [PULSE_CNT_W-1:0] count_q;

  // The mask register is kept at zero whenever the state is IDLE, so it can
  // be OR-ed into the output without qualifying it by state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      count_q <= '0;
    end else if (abort_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      count_q <= '0;
    end else if (trigger_i && (len_i != '0)) begin
      // Same path for a fresh start and a retrigger.
      state_q <= ACTIVE;
      mask_q  <= mask_i;
      count_q <= len_i;
    end else if (state_q == ACTIVE) begin
      if (count_q == PULSE_CNT_W'(1)) begin
        state_q <= IDLE;
        mask_q  <= '0;
        count_q <= '0;
      end else begin
        count_q <= count_q - PULSE_CNT_W'(1);
      end
    end
  end

  assign active_mask_o = mask_q;
  assign busy_o        = (state_q == ACTIVE);
  assign remaining_o   = count_q;

endmodule : niosbase_pio_pulse_timer
`default_nettype wire

// File: rtl/niosbase_pio_out.sv
`default_nettype none
// ============================================================================
//  Module      : niosbase_pio_out
//  Description : Avalon-MM output PIO for NiosBase. A data register drives
//                out_port; a pulse timer ORs a timed mask on top of it.
//                Optional per-bit set/clear writes at addresses 4/5 are
//                built only when NIOSBASE_PIO_OUT_BITSETCLR_EN is defined;
//                otherwise those addresses are reserved.
//  Ports       : clk       system clock
//                reset_n   async active-low reset
//                bus       Avalon-MM slave (niosbase_pio_out_if.slave)
//                out_port  registered output pins
//  Revision    : 1.0 - initial release
// ============================================================================
module niosbase_pio_out
  import niosbase_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    PULSE_CNT_W = 16
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  niosbase_pio_out_if.slave   bus,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   mask_wr;

  logic [DATA_WIDTH-1:0]  data_q,     data_d;
  logic [PULSE_CNT_W-1:0] len_q,      len_d;
  logic [BUS_DW-1:0]      readdata_q, readdata_d;
  logic [DATA_WIDTH-1:0]  out_q,      out_d;

  logic [DATA_WIDTH-1:0]  pulse_mask;
  logic                   pulse_busy;
  logic [PULSE_CNT_W-1:0] pulse_remaining;

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign wr_data = bus.writedata[DATA_WIDTH-1:0];
  assign mask_wr = wr_en && (bus.address == ADDR_PULSE_MASK);

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:      data_d = wr_data;
        ADDR_PULSE_LEN: len_d  = bus.writedata[PULSE_CNT_W-1:0];
`ifdef NIOSBASE_PIO_OUT_BITSETCLR_EN
        ADDR_OUTSET:    data_d = data_q | wr_data;
        ADDR_OUTCLR:    data_d = data_q & ~wr_data;
`endif
        default: ;
      endcase
    end
  end

  // The timer sees the length register as it was before this edge, so a
  // length write never disturbs a pulse that is already running.
  niosbase_pio_pulse_timer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PULSE_CNT_W (PULSE_CNT_W)
  ) u_pulse_timer (
    .clk           (clk),
    .reset_n       (reset_n),
    .trigger_i     (mask_wr && (wr_data != '0)),
    .abort_i       (mask_wr && (wr_data == '0)),
    .mask_i        (wr_data),
    .len_i         (len_q),
    .active_mask_o (pulse_mask),
    .busy_o        (pulse_busy),
    .remaining_o   (pulse_remaining)
  );

  // Read mux follows address every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:       readdata_d = BUS_DW'(data_q);
      ADDR_PULSE_MASK: readdata_d = BUS_DW'(pulse_mask);
      ADDR_PULSE_LEN:  readdata_d = BUS_DW'(len_q);
      ADDR_STATUS: begin
        readdata_d[STATUS_BUSY_BIT]                = pulse_busy;
        readdata_d[STATUS_CNT_LSB +: PULSE_CNT_W]  = pulse_remaining;
      end
      default: ;
    endcase
  end

  assign out_d = data_q | pulse_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      len_q      <= '0;
      readdata_q <= '0;
      out_q      <= RESET_VALUE;
    end else begin
      data_q     <= data_d;
      len_q      <= len_d;
      readdata_q <= readdata_d;
      out_q      <= out_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign out_port     = out_q;

endmodule : niosbase_pio_out
`default_nettype wire
